// File: rtl/alu_reg_seq.sv
// Sequenced register-file ALU core: 2^ADDR_W x DATA_W regs, 8-op ALU, Start/Busy/Done handshake.
// Optional macro ALU_REG_CF_EN adds a latched carry/borrow output CF.
//
// state | meaning
// IDLE  | waiting for Start; load port active
// READ  | operands sampled from the register file
// EXEC  | ALU result and flags latched
// WB    | Done pulse; optional writeback
module alu_reg_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic              Write_Reg,
  input  logic [2:0]        ALU_OP,
  input  logic              Load_En,
  input  logic [ADDR_W-1:0] Load_Addr,
  input  logic [DATA_W-1:0] Load_Data,
  input  logic [ADDR_W-1:0] Dbg_Addr,
  output logic [DATA_W-1:0] Dbg_Data,
  output logic              Busy,
  output logic              Done,
  output logic              ZF,
  output logic              OF,
`ifdef ALU_REG_CF_EN
  output logic              CF,
`endif
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B,
  output logic [DATA_W-1:0] W_Data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SH_W  = $clog2(DATA_W);

  localparam logic [2:0] OP_AND = 3'b000, OP_OR  = 3'b001, OP_XOR = 3'b010, OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100, OP_SUB = 3'b101, OP_SLT = 3'b110, OP_SLL = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] w_addr_q;
  logic              write_reg_q;
  logic [2:0]        alu_op_q;

  logic              is_sub;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_of;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: if (Start) state_nxt = READ;
      READ: begin Busy = 1'b1; state_nxt = EXEC; end
      EXEC: begin Busy = 1'b1; state_nxt = WB; end
      WB:   begin Busy = 1'b1; Done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Reg 0 is never written, so it reads back as zero everywhere.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == IDLE && Load_En && Load_Addr != '0) begin
      regs[Load_Addr] <= Load_Data;
    end else if (state == WB && write_reg_q && w_addr_q != '0) begin
      regs[w_addr_q] <= W_Data;
    end
  end

  assign Dbg_Data = regs[Dbg_Addr];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      w_addr_q    <= '0;
      write_reg_q <= 1'b0;
      alu_op_q    <= '0;
      R_Data_A    <= '0;
      R_Data_B    <= '0;
    end else begin
      if (state == IDLE && Start) begin
        w_addr_q    <= W_Addr;
        write_reg_q <= Write_Reg;
        alu_op_q    <= ALU_OP;
      end
      if (state == READ) begin
        R_Data_A <= regs[R_Addr_A];
        R_Data_B <= regs[R_Addr_B];
      end
    end
  end

  // SUB shares the adder as A + ~B + 1; carry-out of that is the inverted borrow.
  always_comb begin
    is_sub  = (alu_op_q == OP_SUB);
    b_eff   = is_sub ? ~R_Data_B : R_Data_B;
    sum     = {1'b0, R_Data_A} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    alu_res = '0;
    alu_of  = 1'b0;
    case (alu_op_q)
      OP_AND: alu_res = R_Data_A & R_Data_B;
      OP_OR:  alu_res = R_Data_A | R_Data_B;
      OP_XOR: alu_res = R_Data_A ^ R_Data_B;
      OP_NOR: alu_res = ~(R_Data_A | R_Data_B);
      OP_ADD, OP_SUB: begin
        alu_res = sum[DATA_W-1:0];
        alu_of  = (R_Data_A[DATA_W-1] == b_eff[DATA_W-1]) &&
                  (sum[DATA_W-1] != R_Data_A[DATA_W-1]);
      end
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(R_Data_A) < $signed(R_Data_B))};
      OP_SLL: alu_res = R_Data_B << R_Data_A[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      W_Data <= '0;
      ZF     <= 1'b0;
      OF     <= 1'b0;
    end else if (state == EXEC) begin
      W_Data <= alu_res;
      ZF     <= (alu_res == '0);
      OF     <= alu_of;
    end
  end

`ifdef ALU_REG_CF_EN
  logic alu_cf;

  always_comb begin
    case (alu_op_q)
      OP_ADD:  alu_cf = sum[DATA_W];
      OP_SUB:  alu_cf = ~sum[DATA_W];
      default: alu_cf = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)              CF <= 1'b0;
    else if (state == EXEC) CF <= alu_cf;
  end
`endif

endmodule

// File: doc/alu_reg_seq.md
Name: alu_reg_seq

Overview:
- Parametrised successor to the fixed 32x32 ALU_REG datapath: a 2^ADDR_W x DATA_W register file, two read ports, one write port, and an 8-op ALU with flags.
- A Start/Busy/Done handshake sequences each operation through read, execute and writeback.
- A load port preloads registers; a debug read port exposes register contents.
- Sits as the execution core under the lab CPU controller.

Parameters:
- DATA_W, 32, operand/register width (>=8).
- ADDR_W, 5, register address width; depth = 2^ADDR_W.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears FSM, outputs and all registers.
- Start  input  1  request one operation; accepted only in IDLE.
- R_Addr_A  input  ADDR_W  operand A register.
- R_Addr_B  input  ADDR_W  operand B register.
- W_Addr  input  ADDR_W  destination register.
- Write_Reg  input  1  write result back when 1.
- ALU_OP  input  3  operation select.
- Load_En  input  1  preload strobe; honoured only in IDLE.
- Load_Addr  input  ADDR_W  preload address.
- Load_Data  input  DATA_W  preload data.
- Dbg_Addr  input  ADDR_W  debug read address.
- Dbg_Data  output  DATA_W  combinational read of reg[Dbg_Addr].
- Busy  output  1  high in READ, EXEC, WB.
- Done  output  1  one-cycle pulse in WB.
- ZF  output  1  result == 0.
- OF  output  1  signed overflow (ADD/SUB only).
- R_Data_A  output  DATA_W  latched operand A.
- R_Data_B  output  DATA_W  latched operand B.
- W_Data  output  DATA_W  latched ALU result.

Behaviour:
- Reset: state IDLE; Busy=Done=ZF=OF=0; R_Data_A=R_Data_B=W_Data=0; all registers 0. Asynchronous assertion aborts any in-flight operation with no writeback.
- Reg 0 always reads 0. Writes to reg 0 from either the load port or writeback are dropped.
- FSM transitions:
  - IDLE -> READ on Start. W_Addr, Write_Reg and ALU_OP are latched at acceptance.
  - READ -> EXEC: R_Data_A/B latch reg[R_Addr_A]/reg[R_Addr_B], sampled in READ.
  - EXEC -> WB: W_Data, ZF and OF latch.
  - WB -> IDLE: Done=1; reg[W_Addr]<=W_Data if Write_Reg. The written value is visible on Dbg_Data the cycle after WB.
- Latency: Start accepted at edge N; Done high during cycle N+3. Next Start is accepted from the first IDLE cycle, giving 4 cycles per operation.
- Start while Busy is ignored (not queued). Load_En while Busy is ignored.
- Load_En and Start in the same IDLE cycle: both are taken. The load commits at that edge, so READ observes the loaded value.
- R_Addr_A/B are sampled in READ, not at Start. The controller must hold them stable through READ.
- ALU ops, all DATA_W-bit, result truncated:
  - 000 AND; 001 OR; 010 XOR; 011 NOR.
  - 100 ADD; 101 SUB (A-B).
  - 110 SLT signed (result 1 or 0).
  - 111 SLL: B << A[log2(DATA_W)-1:0].
- OF = sign(A)==sign(B')!=sign(result) for ADD/SUB, where B'=~B for SUB; otherwise 0.
- ZF valid for every op.
- Flags and W_Data hold their values until the next EXEC.

Optional Feature:
- ALU_REG_CF_EN defined: adds output CF (1 bit, reset 0), latched in EXEC.
  - ADD: carry-out of bit DATA_W-1.
  - SUB: borrow (A<B unsigned).
  - All other ops: 0.
- Undefined: CF port absent. All other behaviour is identical.

Test Plan:
- Reset, Dbg sweep of every address -> all Dbg_Data=0, Busy=0. Load r1=5, r2=7, then Start ADD A=1 B=2 W=3 Write_Reg=1 -> Done at cycle N+3, W_Data=12, ZF=0, OF=0, Dbg r3=12.
- SUB A=1 B=1 W=4 -> W_Data=0, ZF=1. With ALU_REG_CF_EN: CF=0. Load r5=0x7FFFFFFF, r6=1, ADD -> W_Data=0x80000000, OF=1.
- Write_Reg=1, W_Addr=0, ADD r1+r2 -> Done pulses, Dbg r0 stays 0. Write_Reg=0, W_Addr=7 -> r7 unchanged.
- Start and Load_En pulsed during READ/EXEC -> ignored: exactly one Done, target registers unchanged. Same-cycle Load r1=9 and Start ADD r1+r2 -> W_Data=16.
- Reset asserted mid-EXEC -> immediately Busy=0, outputs 0, no Done, destination register 0. SLT with r1=-1 (0xFFFFFFFF), r2=1 -> W_Data=1. SLL with A=4, B=1 -> W_Data=16.
